glyph_draw_sched: RTL and testbench

- Round-robin scheduler that shares one glyph-fetch pipeline between NUM_REQ character requesters.
- Each requester owns a 128x1 synchronous glyph ROM holding an 8-wide x 16-tall bitmap, row-major, address = row*8 + col.
- The block drives a common ROM address, selects which ROM's q to use, walks all 128 pixels of the granted glyph and emits a ready/valid pixel stream with screen coordinates to the TFT frame writer.

---
 rtl/glyph_draw_sched.sv | 163 ++++++++++++++++
 tb/tb_glyph_draw_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_draw_sched.sv
// glyph_draw_sched: round-robin arbiter sharing one glyph-ROM fetch pipeline between
// NUM_REQ requesters; walks the granted 8x16 glyph and streams pixels with screen coordinates.
`timescale 1ns/1ps
module glyph_draw_sched #(
    parameter int NUM_REQ = 4,
    parameter int X_W     = 10,
    parameter int Y_W     = 10
) (
    input  logic                   clock,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*X_W-1:0] req_x,
    input  logic [NUM_REQ*Y_W-1:0] req_y,
    output logic [NUM_REQ-1:0]     gnt,
    output logic                   busy,
    output logic                   done,
    output logic [6:0]             rom_address,
    output logic [NUM_REQ-1:0]     rom_sel,
    input  logic [NUM_REQ-1:0]     rom_q,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic [X_W-1:0]         pix_x,
    output logic [Y_W-1:0]         pix_y,
    output logic                   pix_on,
    output logic                   pix_last
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   ptr_nxt;
    logic [NUM_REQ-1:0] sel_q;
    logic [6:0]         idx;
    logic [X_W-1:0]     x0;
    logic [Y_W-1:0]     y0;
    logic               take;

    logic               win;
    logic               wrap_hit;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   wrap_idx;
    logic [NUM_REQ-1:0] win_oh;
    logic [X_W-1:0]     win_x;
    logic [Y_W-1:0]     win_y;

    // Lowest set request at or above the pointer wins; otherwise the lowest set request overall.
    always_comb begin
        win      = 1'b0;
        wrap_hit = 1'b0;
        win_idx  = '0;
        wrap_idx = '0;
        win_oh   = '0;
        win_x    = '0;
        win_y    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                wrap_hit = 1'b1;
                wrap_idx = PTR_W'(i);
                if (i >= int'(ptr)) begin
                    win     = 1'b1;
                    win_idx = PTR_W'(i);
                end
            end
        end
        if (!win) begin
            win     = wrap_hit;
            win_idx = wrap_idx;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_idx == PTR_W'(i)) begin
                win_oh[i] = 1'b1;
                win_x     = req_x[i*X_W +: X_W];
                win_y     = req_y[i*Y_W +: Y_W];
            end
        end
    end

    assign ptr_nxt = (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + PTR_W'(1);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: every sequential assignment is non-blocking so all registers see pre-edge values.
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path through the case can infer a latch.
        state_nxt   = state;
        take        = 1'b0;
        gnt         = '0;
        busy        = 1'b0;
        done        = 1'b0;
        rom_address = '0;
        rom_sel     = '0;
        pix_valid   = 1'b0;
        case (state)
            IDLE: begin
                // Grant is combinational in IDLE; gating with rst_n keeps it low during reset.
                if (rst_n && win) begin
                    take      = 1'b1;
                    gnt       = win_oh;
                    busy      = 1'b1;
                    rom_sel   = win_oh;
                    state_nxt = PRIME;
                end
            end
            PRIME: begin
                busy      = 1'b1;
                rom_sel   = sel_q;
                state_nxt = STREAM;
            end
            STREAM: begin
                busy      = 1'b1;
                rom_sel   = sel_q;
                pix_valid = 1'b1;
                // A stalled pixel re-reads its own address so rom_q holds steady next cycle.
                if (pix_ready) begin
                    rom_address = idx + 7'd1;
                    if (idx == 7'd127) state_nxt = DONE;
                end else begin
                    rom_address = idx;
                end
            end
            DONE: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            sel_q <= '0;
            idx   <= '0;
            x0    <= '0;
            y0    <= '0;
        end else begin
            if (take) begin
                ptr   <= ptr_nxt;
                sel_q <= win_oh;
                x0    <= win_x;
                y0    <= win_y;
                idx   <= '0;
            end
            if (state == STREAM && pix_ready && idx != 7'd127) idx <= idx + 7'd1;
        end
    end

    assign pix_on   = pix_valid & |(rom_q & sel_q);
    assign pix_x    = pix_valid ? x0 + X_W'(idx[2:0]) : '0;
    assign pix_y    = pix_valid ? y0 + Y_W'(idx[6:3]) : '0;
    assign pix_last = pix_valid & (idx == 7'd127);

endmodule

// File: tb/tb_glyph_draw_sched.sv
// Directed self-checking bench for glyph_draw_sched: ROM model per requester, per-draw
// pixel capture compared against hand-derived coordinates and ROM contents.
`timescale 1ns/1ps
module tb_glyph_draw_sched;
    logic        clock = 1'b0;
    logic        rst_n;
    logic [3:0]  req;
    logic [39:0] req_x;
    logic [39:0] req_y;
    logic [3:0]  gnt;
    logic        busy;
    logic        done;
    logic [6:0]  rom_address;
    logic [3:0]  rom_sel;
    logic [3:0]  rom_q = '0;
    logic        pix_valid;
    logic        pix_ready;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        pix_on;
    logic        pix_last;

    logic [127:0] rom_mem [4];
    int   cap_x [128];
    int   cap_y [128];
    logic cap_on [128];
    logic cap_last [128];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   stall_cycles;

    glyph_draw_sched #(.NUM_REQ(4), .X_W(10), .Y_W(10)) dut (
        .clock(clock), .rst_n(rst_n), .req(req), .req_x(req_x), .req_y(req_y),
        .gnt(gnt), .busy(busy), .done(done), .rom_address(rom_address),
        .rom_sel(rom_sel), .rom_q(rom_q), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_x(pix_x), .pix_y(pix_y), .pix_on(pix_on), .pix_last(pix_last)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        for (int r = 0; r < 4; r++) rom_q[r] <= rom_mem[r][rom_address];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic set_origin(input int k, input int x, input int y);
        req_x[k*10 +: 10] = 10'(x);
        req_y[k*10 +: 10] = 10'(y);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, ".gnt"}, gnt, 0);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".done"}, done, 0);
        check({tag, ".rom_address"}, rom_address, 0);
        check({tag, ".rom_sel"}, rom_sel, 0);
        check({tag, ".pix_valid"}, pix_valid, 0);
        check({tag, ".pix_xy_on_last"}, {pix_x, pix_y, pix_on, pix_last}, 0);
    endtask

    // Called in the grant cycle; returns in the cycle after done.
    // mode 0: ready always high; 1: toggling with a 5-cycle stall at pixel 40; 2: ready high, req[1] pulse.
    task automatic run_draw(input int k, input int x0, input int y0, input int mode,
                            input logic [3:0] clr_mask);
        int e = 0, first_rel = -1, done_rel = -1, stall = 0;
        int bad_busy = 0, bad_sel = 0, bad_gnt = 0, gaps = 0, unstable = 0;
        int bad_x = 0, bad_y = 0, bad_on = 0, bad_last = 0;
        bit tog = 1'b1, held = 1'b0, rdy;
        int hx = 0, hy = 0;
        logic hon = 1'b0, hlast = 1'b0;
        stall_cycles = 0;
        for (int rel = 1; rel <= 600 && done_rel < 0; rel++) begin
            @(negedge clock);
            if (rel == 1) req = req & ~clr_mask;
            if (mode == 2 && rel == 20) req[1] = 1'b1;
            if (mode == 2 && rel == 21) req[1] = 1'b0;
            rdy = 1'b1;
            if (mode == 1) begin
                if (e == 40 && stall < 5) begin
                    rdy = 1'b0;
                    stall++;
                end else begin
                    rdy = tog;
                    tog = !tog;
                end
            end
            pix_ready = rdy;
            #1;
            if (done) begin
                done_rel = rel;
                check("draw.done_busy", busy, 1);
                check("draw.done_valid", pix_valid, 0);
                check("draw.done_rom_sel", rom_sel, 0);
                check("draw.done_rom_address", rom_address, 0);
                check("draw.done_gnt", gnt, 0);
            end else begin
                if (busy !== 1'b1) bad_busy++;
                if (gnt !== 4'b0) bad_gnt++;
                if (rom_sel !== 4'(1 << k)) bad_sel++;
                if (pix_valid) begin
                    if (first_rel < 0) first_rel = rel;
                    if (held && (pix_x != hx || pix_y != hy || pix_on !== hon || pix_last !== hlast))
                        unstable++;
                    held  = !pix_ready;
                    hx    = pix_x;
                    hy    = pix_y;
                    hon   = pix_on;
                    hlast = pix_last;
                    if (!pix_ready) stall_cycles++;
                    if (pix_ready && e < 128) begin
                        cap_x[e]    = pix_x;
                        cap_y[e]    = pix_y;
                        cap_on[e]   = pix_on;
                        cap_last[e] = pix_last;
                        e++;
                    end
                end else if (first_rel >= 0) begin
                    gaps++;
                end
            end
        end
        check("draw.done_seen", done_rel > 0, 1);
        check("draw.first_valid_rel", first_rel, 2);
        if (mode != 1) check("draw.done_rel", done_rel, 130);
        check("draw.pixel_count", e, 128);
        for (int i = 0; i < e; i++) begin
            if (cap_x[i] != (x0 + i % 8) % 1024) bad_x++;
            if (cap_y[i] != (y0 + i / 8) % 1024) bad_y++;
            if (cap_on[i] !== rom_mem[k][i]) bad_on++;
            if (cap_last[i] !== (i == 127)) bad_last++;
        end
        check("draw.bad_x", bad_x, 0);
        check("draw.bad_y", bad_y, 0);
        check("draw.bad_on", bad_on, 0);
        check("draw.bad_last", bad_last, 0);
        check("draw.gaps", gaps, 0);
        check("draw.unstable_hold", unstable, 0);
        check("draw.busy_low", bad_busy, 0);
        check("draw.rom_sel_wrong", bad_sel, 0);
        check("draw.gnt_during_draw", bad_gnt, 0);
        @(negedge clock);
        #1;
        check("draw.done_one_pulse", done, 0);
    endtask

    int order [5] = '{0, 1, 2, 3, 0};
    int done_seen;

    initial begin
        rom_mem[0] = 128'h3C5A_9F01_E7D2_4B86_0A5F_C3E1_7B29_D46E;
        rom_mem[0][26] = 1'b1;
        rom_mem[0][25] = 1'b0;
        rom_mem[1] = 128'h9D3E_5A71_02CB_F468_E15B_7A30_C84D_269F;
        rom_mem[2] = 128'h7F00_A5A5_1234_5678_9ABC_DEF0_0FF0_C33C;
        rom_mem[3] = 128'hB6E1_2D9C_4F70_83AA_5C1E_F027_69D4_3B85;

        rst_n = 1'b0;
        req = 4'b1111;
        pix_ready = 1'b0;
        req_x = '0;
        req_y = '0;
        for (int k = 0; k < 4; k++) set_origin(k, 10 + 100 * k, 20 + 50 * k);
        repeat (3) @(negedge clock);
        #1;
        check_idle_zero("reset");

        // Round-robin with all requests held; requester 0 wins at reset exit.
        @(negedge clock);
        rst_n = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            check($sformatf("rr.gnt%0d", g), gnt, 1 << order[g]);
            check($sformatf("rr.rom_sel%0d", g), rom_sel, 1 << order[g]);
            check($sformatf("rr.busy%0d", g), busy, 1);
            check($sformatf("rr.rom_address%0d", g), rom_address, 0);
            run_draw(order[g], 10 + 100 * order[g], 20 + 50 * order[g], 0,
                     (g == 4) ? 4'b1111 : 4'b0000);
        end
        check("rr.end_busy", busy, 0);
        check("rr.end_gnt", gnt, 0);

        // Single draw from requester 0 at (100,50).
        @(negedge clock);
        set_origin(0, 100, 50);
        req = 4'b0001;
        #1;
        check("single.gnt", gnt, 4'b0001);
        check("single.rom_sel", rom_sel, 4'b0001);
        run_draw(0, 100, 50, 0, 4'b0001);
        check("single.p25_x", cap_x[25], 101);
        check("single.p25_y", cap_y[25], 53);
        check("single.p25_on", cap_on[25], 0);
        check("single.p26_x", cap_x[26], 102);
        check("single.p26_y", cap_y[26], 53);
        check("single.p26_on", cap_on[26], 1);
        check("single.p127_x", cap_x[127], 107);
        check("single.p127_y", cap_y[127], 65);
        check("single.p127_last", cap_last[127], 1);
        check("single.after_busy", busy, 0);

        // Backpressure on requester 1.
        @(negedge clock);
        set_origin(1, 200, 300);
        req = 4'b0010;
        #1;
        check("bp.gnt", gnt, 4'b0010);
        run_draw(1, 200, 300, 1, 4'b0010);
        check("bp.stalled", stall_cycles >= 5, 1);
        check("bp.p40_x", cap_x[40], 200);
        check("bp.p40_y", cap_y[40], 305);
        check("bp.after_busy", busy, 0);

        // Coordinate wrap on requester 2.
        @(negedge clock);
        set_origin(2, 1020, 1015);
        req = 4'b0100;
        #1;
        check("wrap.gnt", gnt, 4'b0100);
        run_draw(2, 1020, 1015, 0, 4'b0100);
        check("wrap.p3_x", cap_x[3], 1023);
        check("wrap.p4_x", cap_x[4], 0);
        check("wrap.p7_x", cap_x[7], 3);
        check("wrap.p7_y", cap_y[7], 1015);
        check("wrap.p127_x", cap_x[127], 3);
        check("wrap.p127_y", cap_y[127], 6);

        // Reset in the middle of a draw for requester 3, at pixel 60.
        @(negedge clock);
        set_origin(3, 40, 60);
        req = 4'b1000;
        #1;
        check("rst.gnt", gnt, 4'b1000);
        for (int rel = 1; rel <= 62; rel++) begin
            @(negedge clock);
            req = 4'b0000;
            pix_ready = 1'b1;
            #1;
        end
        check("rst.p60_valid", pix_valid, 1);
        check("rst.p60_x", pix_x, 44);
        check("rst.p60_y", pix_y, 67);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_zero("rst.async");
        done_seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            #1;
            if (done) done_seen++;
        end
        check("rst.no_done", done_seen, 0);
        @(negedge clock);
        rst_n = 1'b1;
        req = 4'b0100;
        #1;
        check("rst.regnt", gnt, 4'b0100);
        run_draw(2, 1020, 1015, 0, 4'b0100);

        // Withdrawal: req[1] pulses for one cycle during a draw for requester 0.
        @(negedge clock);
        req = 4'b0001;
        #1;
        check("wd.gnt", gnt, 4'b0001);
        run_draw(0, 100, 50, 2, 4'b0001);
        check("wd.idle_gnt", gnt, 0);
        check("wd.idle_busy", busy, 0);
        @(negedge clock);
        #1;
        check("wd.idle_gnt2", gnt, 0);
        check("wd.idle_busy2", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
